// File: rtl/cg_iteration_sequencer.sv
// =============================================================================
// cg_iteration_sequencer : conjugate-gradient stage sequencer with convergence/timeout control. Rev 1.0
// =============================================================================
`default_nettype none

module cg_iteration_sequencer #(
  parameter int          MAX_ITERATIONS = 10,
  parameter logic [31:0] TOLERANCE      = 32'h283424DC,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic             vXv1_finish,
  input  logic             mXv1_finish,
  input  logic             div1_finish,
  input  logic             mul_add1_finish,
  input  logic             mul_add2_finish,
  input  logic             vXv3_finish,
  input  logic [31:0]      rsnew,
  input  logic             div2_finish,
  input  logic             mul_add3_finish,
  output logic             reset_vXv1,
  output logic             reset_mXv1,
  output logic             run_div1,
  output logic             run_mul_add,
  output logic             run_vXv3,
  output logic             run_div2,
  output logic             run_mul_add3,
  output logic [CNT_W-1:0] iteration_count,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic             timeout_error
);

  localparam int                 c_TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_MAX_CNT  = CNT_W'(MAX_ITERATIONS);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RSOLD_AP  = 4'd1,
    S_ALPHA     = 4'd2,
    S_UPDATE_XR = 4'd3,
    S_RSNEW     = 4'd4,
    S_CHECK     = 4'd5,
    S_BETA      = 4'd6,
    S_UPDATE_P  = 4'd7,
    S_RESTART   = 4'd8,
    S_DONE      = 4'd9,
    S_ERROR     = 4'd10
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_vxv1_seen;
  logic               r_mxv1_seen;
  logic               r_ma1_seen;
  logic               r_ma2_seen;
  logic [30:0]        r_rs_mag;

  logic               w_blank;
  logic               w_timeout;
  logic               w_wait;
  logic               w_idle_class;
  logic               w_vxv1;
  logic               w_mxv1;
  logic               w_ma1;
  logic               w_ma2;
  logic               w_conv;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_unused;

  // Timer is zero exactly in the entry cycle of a phase, which is the blanked cycle.
  assign w_blank      = (r_timer == '0);
  assign w_timeout    = (r_timer == c_TMR_LAST);
  assign w_wait       = r_state inside {S_RSOLD_AP, S_ALPHA, S_UPDATE_XR, S_RSNEW, S_BETA, S_UPDATE_P};
  assign w_idle_class = r_state inside {S_IDLE, S_DONE, S_ERROR};

  assign w_vxv1 = r_vxv1_seen | (vXv1_finish & ~w_blank);
  assign w_mxv1 = r_mxv1_seen | (mXv1_finish & ~w_blank);
  assign w_ma1  = r_ma1_seen  | (mul_add1_finish & ~w_blank);
  assign w_ma2  = r_ma2_seen  | (mul_add2_finish & ~w_blank);

  // Magnitude compare only; an all-ones exponent (NaN/Inf) never counts as converged.
  assign w_conv    = (r_rs_mag[30:23] != 8'hFF) && (r_rs_mag < TOLERANCE[30:0]);
  assign w_cnt_inc = iteration_count + 1'b1;
  assign w_unused  = rsnew[31];

  always_comb begin
    w_next = r_state;
    if (w_idle_class) begin
      if (go && !abort) w_next = S_RSOLD_AP;
    end else if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_RSOLD_AP: begin
          if (w_vxv1 && w_mxv1)      w_next = S_ALPHA;
          else if (w_timeout)        w_next = S_ERROR;
        end
        S_ALPHA: begin
          if (div1_finish && !w_blank) w_next = S_UPDATE_XR;
          else if (w_timeout)          w_next = S_ERROR;
        end
        S_UPDATE_XR: begin
          if (w_ma1 && w_ma2)        w_next = S_RSNEW;
          else if (w_timeout)        w_next = S_ERROR;
        end
        S_RSNEW: begin
          if (vXv3_finish && !w_blank) w_next = S_CHECK;
          else if (w_timeout)          w_next = S_ERROR;
        end
        S_CHECK: begin
          if (w_conv)                      w_next = S_DONE;
          else if (w_cnt_inc == c_MAX_CNT) w_next = S_DONE;
          else                             w_next = S_BETA;
        end
        S_BETA: begin
          if (div2_finish && !w_blank) w_next = S_UPDATE_P;
          else if (w_timeout)          w_next = S_ERROR;
        end
        S_UPDATE_P: begin
          if (mul_add3_finish && !w_blank) w_next = S_RESTART;
          else if (w_timeout)              w_next = S_ERROR;
        end
        S_RESTART: w_next = S_RSOLD_AP;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_vxv1_seen     <= 1'b0;
      r_mxv1_seen     <= 1'b0;
      r_ma1_seen      <= 1'b0;
      r_ma2_seen      <= 1'b0;
      r_rs_mag        <= '0;
      reset_vXv1      <= 1'b1;
      reset_mXv1      <= 1'b1;
      run_div1        <= 1'b0;
      run_mul_add     <= 1'b0;
      run_vXv3        <= 1'b0;
      run_div2        <= 1'b0;
      run_mul_add3    <= 1'b0;
      iteration_count <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      converged       <= 1'b0;
      timeout_error   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state) begin
        r_timer     <= '0;
        r_vxv1_seen <= 1'b0;
        r_mxv1_seen <= 1'b0;
        r_ma1_seen  <= 1'b0;
        r_ma2_seen  <= 1'b0;
      end else begin
        if (w_wait) r_timer <= r_timer + 1'b1;
        if (r_state == S_RSOLD_AP) begin
          r_vxv1_seen <= w_vxv1;
          r_mxv1_seen <= w_mxv1;
        end
        if (r_state == S_UPDATE_XR) begin
          r_ma1_seen <= w_ma1;
          r_ma2_seen <= w_ma2;
        end
      end

      if (r_state == S_RSNEW && w_next == S_CHECK) r_rs_mag <= rsnew[30:0];

      // Outputs are decoded from the next state so they line up with the state register.
      reset_vXv1    <= w_next inside {S_IDLE, S_RESTART, S_DONE, S_ERROR};
      reset_mXv1    <= w_next inside {S_IDLE, S_RESTART, S_DONE, S_ERROR};
      run_div1      <= w_next inside {S_ALPHA, S_UPDATE_XR};
      run_mul_add   <= (w_next == S_UPDATE_XR);
      run_vXv3      <= (w_next == S_RSNEW);
      run_div2      <= w_next inside {S_BETA, S_UPDATE_P};
      run_mul_add3  <= (w_next == S_UPDATE_P);
      busy          <= !(w_next inside {S_IDLE, S_DONE, S_ERROR});
      done          <= (w_next == S_DONE);
      timeout_error <= (w_next == S_ERROR);
      converged     <= (w_next == S_DONE) && ((r_state == S_CHECK) ? w_conv : converged);

      if (w_next == S_IDLE || (w_idle_class && w_next == S_RSOLD_AP))
        iteration_count <= '0;
      else if (r_state == S_CHECK)
        iteration_count <= w_cnt_inc;
    end
  end

endmodule

`default_nettype wire

// File: doc/cg_iteration_sequencer.md
Name: cg_iteration_sequencer

Overview:
- Top-level sequencer for the conjugate-gradient ALU datapath.
- Drives the run/reset levels of each stage in order: r·r plus A·p, alpha divide, x/r update, rsnew dot product, beta divide, p update.
- Checks rsnew against a tolerance and repeats until the solution converges, the iteration limit is reached, or a stage hangs.
- Sits between the host start/status interface and the ALU stage enables.

Parameters:
MAX_ITERATIONS, 10, iteration limit; legal range 1..65535.
TOLERANCE, 32'h283424DC, IEEE-754 single convergence threshold on rsnew.
TIMEOUT_CYCLES, 4096, maximum cycles any single phase may wait for its finish.
CNT_W, 16, width of iteration_count.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
go  in  1  start a solve; sampled only in IDLE, DONE or ERROR.
abort  in  1  synchronous abort of the current solve.
vXv1_finish  in  1  rsold dot product complete (level).
mXv1_finish  in  1  A·p complete (level).
div1_finish  in  1  alpha valid (level).
mul_add1_finish  in  1  x update complete (level).
mul_add2_finish  in  1  r update complete (level).
vXv3_finish  in  1  rsnew dot product complete (level).
rsnew  in  32  rsnew value, valid while vXv3_finish is high.
div2_finish  in  1  beta valid (level).
mul_add3_finish  in  1  p update complete (level).
reset_vXv1  out  1  active-high hold reset for vXv1.
reset_mXv1  out  1  active-high hold reset for mXv1.
run_div1  out  1  div1 enable.
run_mul_add  out  1  enable for mul_add1 and mul_add2.
run_vXv3  out  1  vXv3 enable.
run_div2  out  1  div2 enable.
run_mul_add3  out  1  mul_add3 enable.
iteration_count  out  CNT_W  number of completed iterations.
busy  out  1  solve in progress.
done  out  1  solve ended: converged or limit reached.
converged  out  1  rsnew was below TOLERANCE.
timeout_error  out  1  a phase exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset (async) values: all outputs 0, except reset_vXv1 = 1 and reset_mXv1 = 1. State is IDLE and all counters are 0.
- All outputs are registered. A stage's run level is asserted in the first cycle of its phase and dropped when the phase is exited.
- States and transitions:
  - IDLE: on go, clear done, converged, timeout_error and iteration_count; go to RSOLD_AP.
  - RSOLD_AP: reset_vXv1 = 0 and reset_mXv1 = 0. Exit when both vXv1_finish and mXv1_finish are high. They may arrive in any order, so each is latched sticky. Go to ALPHA.
  - ALPHA: run_div1 = 1. Exit on div1_finish; go to UPDATE_XR.
  - UPDATE_XR: run_mul_add = 1, with run_div1 held high so alpha stays valid. Exit when both mul_add1_finish and mul_add2_finish have been seen (sticky); go to RSNEW.
  - RSNEW: run_vXv3 = 1. On vXv3_finish, capture rsnew into rs_q; go to CHECK.
  - CHECK (one cycle): iteration_count increments.
    - If rs_q[30:0] < TOLERANCE[30:0] (unsigned compare), go to DONE with converged = 1.
    - Else, if the incremented count equals MAX_ITERATIONS, go to DONE with converged = 0.
    - Else go to BETA.
    - Sign bit is ignored. An rs_q exponent of 8'hFF (NaN/Inf) is never converged.
  - BETA: run_div2 = 1. Exit on div2_finish; go to UPDATE_P.
  - UPDATE_P: run_mul_add3 = 1, with run_div2 held high. Exit on mul_add3_finish. All run levels drop and both hold resets reassert for one cycle, then go to RSOLD_AP.
  - DONE: done = 1, busy = 0. All stage resets asserted, all runs low. go restarts the solve as from IDLE.
  - ERROR: timeout_error = 1, busy = 0. Stages held as in DONE. go restarts the solve.
- busy = 1 in every state except IDLE, DONE and ERROR.
- Blanking: finish inputs are ignored in the first cycle of every phase, so a stale finish from the previous phase cannot advance the FSM.
- Phase timer:
  - Cleared on every state change; increments in the wait states RSOLD_AP, ALPHA, UPDATE_XR, RSNEW, BETA and UPDATE_P.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
  - If a finish arrives in the same cycle as the timeout, the finish wins.
- abort:
  - From any busy state, the next state is IDLE. All runs drop, hold resets assert, and all flags clear.
  - abort in IDLE, DONE or ERROR has no effect.
  - abort has priority over go.
- go while busy is ignored.
- Minimum phase latency: 2 cycles (entry cycle plus the earliest finish sample). CHECK takes exactly 1 cycle.
- Async reset mid-solve: outputs take their reset values immediately, without waiting for a clock edge.

Test Plan:
- Stub stages finish 5 cycles after their run rises; rsnew = 0x3F800000, 0x3C000000, 0x28000000 on iterations 1–3 → done = 1, converged = 1, iteration_count = 3; run_mul_add3 never asserted in iteration 3.
- rsnew fixed at 0x3F800000, MAX_ITERATIONS = 4 → done = 1, converged = 0, iteration_count = 4.
- div2 stub never finishes, TIMEOUT_CYCLES = 64 → ERROR on cycle 64 of BETA: timeout_error = 1, all runs 0, busy = 0; a following go restarts with flags cleared.
- mXv1_finish 10 cycles before vXv1_finish → ALPHA entered only after vXv1_finish. Separately, mul_add1_finish held high from the prior phase → UPDATE_XR does not exit in its first cycle.
- abort in UPDATE_XR → IDLE next cycle, reset_vXv1 = 1, iteration_count = 0. go asserted together with abort → stays IDLE.
- Async reset asserted mid-RSNEW between clock edges → run_vXv3 = 0 and reset_mXv1 = 1 before the next edge. rsnew = 0xA8000000 (negative, small magnitude) at CHECK → converged = 1.
